// File: rtl/buffer_ram_fifo_ctrl_if.sv
// rtl/buffer_ram_fifo_ctrl_if.sv - Bus bundle for the RAM-backed streaming FIFO controller
interface buffer_ram_fifo_ctrl_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 18
);
  logic              iclr;
  logic              ivalid;
  logic [DATA_W-1:0] idata;
  logic              ram_en_wr;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [ADDR_W-1:0] ram_r_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic              ovalid;
  logic              oready;
  logic [DATA_W-1:0] odata;
  logic [ADDR_W:0]   ofill;
  logic              ofull;
  logic              oempty;
  logic              oovf;

  // Controller side
  modport slave (
    input  iclr, ivalid, idata, ram_rdata, oready,
    output ram_en_wr, ram_wr_addr, ram_wdata, ram_r_addr,
           ovalid, odata, ofill, ofull, oempty, oovf
  );

  // Environment side: sample source, RAM and downstream sink
  modport master (
    output iclr, ivalid, idata, ram_rdata, oready,
    input  ram_en_wr, ram_wr_addr, ram_wdata, ram_r_addr,
           ovalid, odata, ofill, ofull, oempty, oovf
  );
endinterface

// File: rtl/buffer_ram_fifo_ctrl.sv
// rtl/buffer_ram_fifo_ctrl.sv - Streams a registered-read dual-port RAM as a FIFO with a 2-entry skid buffer
module buffer_ram_fifo_ctrl #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 18
) (
  input  logic                  iclk,
  input  logic                  irst,
  buffer_ram_fifo_ctrl_if.slave bus
);
  // Pointer difference that means "every RAM word holds an unissued sample"
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   fill;
  logic              full;
  logic [1:0]        skid_count;
  logic              inflight;
  logic              ovf;
  logic [DATA_W-1:0] skid0;
  logic [DATA_W-1:0] skid1;
  logic              accept;
  logic              issue;
  logic              push;
  logic              pop;
  logic [2:0]        occupancy;

  // Handshake decode; a pop this cycle frees a slot so a read can be issued
  // into it, which is what keeps the stream at one word per clock.
  always_comb begin
    fill      = wr_ptr - rd_ptr;
    full      = (fill == DEPTH);
    accept    = bus.ivalid & ~full & ~bus.iclr & ~irst;
    pop       = (skid_count != 2'd0) & bus.oready;
    push      = inflight & ~bus.iclr;
    occupancy = {1'b0, skid_count} + {2'b00, inflight} - {2'b00, pop};
    issue     = (fill != '0) & (occupancy < 3'd2) & ~bus.iclr;
  end

  assign bus.ram_en_wr   = accept;
  assign bus.ram_wr_addr = wr_ptr[ADDR_W-1:0];
  assign bus.ram_wdata   = bus.idata;
  assign bus.ram_r_addr  = rd_ptr[ADDR_W-1:0];
  assign bus.ovalid      = (skid_count != 2'd0);
  assign bus.odata       = skid0;
  assign bus.ofill       = fill;
  assign bus.ofull       = full;
  assign bus.oempty      = (fill == '0) & (skid_count == 2'd0) & ~inflight;
  assign bus.oovf        = ovf;

  // Pointers, in-flight read flag, skid occupancy and sticky overflow
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      inflight   <= 1'b0;
      skid_count <= 2'd0;
      ovf        <= 1'b0;
    end else if (bus.iclr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      inflight   <= 1'b0;
      skid_count <= 2'd0;
      ovf        <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (issue)  rd_ptr <= rd_ptr + 1'b1;
      inflight   <= issue;
      skid_count <= skid_count + {1'b0, push} - {1'b0, pop};
      if (bus.ivalid & full) ovf <= 1'b1;
    end
  end

  // Skid storage: skid0 is the head presented on odata, skid1 the second entry
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      skid0 <= '0;
      skid1 <= '0;
    end else if (push & pop) begin
      if (skid_count == 2'd2) begin
        skid0 <= skid1;
        skid1 <= bus.ram_rdata;
      end else begin
        skid0 <= bus.ram_rdata;
      end
    end else if (push) begin
      if (skid_count == 2'd0) skid0 <= bus.ram_rdata;
      else                    skid1 <= bus.ram_rdata;
    end else if (pop) begin
      skid0 <= skid1;
    end
  end
endmodule

// File: tb/tb_buffer_ram_fifo_ctrl.sv
// tb/tb_buffer_ram_fifo_ctrl.sv - Directed self-checking bench for buffer_ram_fifo_ctrl
module tb_buffer_ram_fifo_ctrl;
  localparam int DW = 24;
  localparam int AW = 4;

  logic iclk;
  logic irst;
  int   passed;
  int   total;

  buffer_ram_fifo_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  buffer_ram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .iclk (iclk),
    .irst (irst),
    .bus  (bus)
  );

  // Simple dual-port RAM with registered read
  logic [DW-1:0] mem [16];
  always @(posedge iclk) begin
    if (bus.ram_en_wr) mem[bus.ram_wr_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_r_addr];
  end

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  task automatic test_reset();
    bus.ivalid = 1'b1;
    bus.idata  = 24'h000011;
    #1;
    total++; if (bus.ovalid !== 1'b0) $display("FAIL rst_ovalid got %0h want 0", bus.ovalid); else passed++;
    total++; if (bus.odata !== 24'h0) $display("FAIL rst_odata got %0h want 0", bus.odata); else passed++;
    total++; if (bus.ofill !== 5'd0) $display("FAIL rst_ofill got %0d want 0", bus.ofill); else passed++;
    total++; if (bus.ofull !== 1'b0) $display("FAIL rst_ofull got %0h want 0", bus.ofull); else passed++;
    total++; if (bus.oempty !== 1'b1) $display("FAIL rst_oempty got %0h want 1", bus.oempty); else passed++;
    total++; if (bus.oovf !== 1'b0) $display("FAIL rst_oovf got %0h want 0", bus.oovf); else passed++;
    total++; if (bus.ram_en_wr !== 1'b0) $display("FAIL rst_en_wr got %0h want 0", bus.ram_en_wr); else passed++;
    bus.ivalid = 1'b0;
    step();
    step();
    irst = 1'b0;
    step();
  endtask

  task automatic test_latency(input logic [DW-1:0] val);
    int   exp_fill [6];
    logic exp_empty [6];
    exp_fill  = '{0, 1, 0, 0, 0, 0};
    exp_empty = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.oready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.ivalid = (c == 0);
      bus.idata  = (c == 0) ? val : '0;
      #1;
      if (c == 0) begin
        total++; if (bus.ram_en_wr !== 1'b1) $display("FAIL lat_en_wr got %0h want 1", bus.ram_en_wr); else passed++;
        total++; if (bus.ram_wr_addr !== 4'd0) $display("FAIL lat_wr_addr got %0h want 0", bus.ram_wr_addr); else passed++;
        total++; if (bus.ram_wdata !== val) $display("FAIL lat_wdata got %0h want %0h", bus.ram_wdata, val); else passed++;
      end
      total++; if (bus.ovalid !== (c == 3)) $display("FAIL lat_ovalid c%0d got %0h want %0h", c, bus.ovalid, (c == 3)); else passed++;
      if (c == 3) begin
        total++; if (bus.odata !== val) $display("FAIL lat_odata got %0h want %0h", bus.odata, val); else passed++;
      end
      total++; if (bus.ofill !== 5'(exp_fill[c])) $display("FAIL lat_ofill c%0d got %0d want %0d", c, bus.ofill, exp_fill[c]); else passed++;
      total++; if (bus.oempty !== exp_empty[c]) $display("FAIL lat_oempty c%0d got %0h want %0h", c, bus.oempty, exp_empty[c]); else passed++;
      step();
    end
  endtask

  task automatic test_overflow();
    int got;
    bus.oready = 1'b0;
    for (int c = 0; c < 19; c++) begin
      bus.ivalid = 1'b1;
      bus.idata  = DW'(c + 1);
      #1;
      total++; if (bus.ram_en_wr !== (c < 18)) $display("FAIL ovf_en_wr c%0d got %0h want %0h", c, bus.ram_en_wr, (c < 18)); else passed++;
      if (c == 18) begin
        total++; if (bus.ofill !== 5'd16) $display("FAIL ovf_fill got %0d want 16", bus.ofill); else passed++;
        total++; if (bus.ofull !== 1'b1) $display("FAIL ovf_full got %0h want 1", bus.ofull); else passed++;
        total++; if (bus.oovf !== 1'b0) $display("FAIL ovf_early got %0h want 0", bus.oovf); else passed++;
      end
      step();
    end
    bus.ivalid = 1'b0;
    bus.oready = 1'b1;
    #1;
    total++; if (bus.oovf !== 1'b1) $display("FAIL ovf_flag got %0h want 1", bus.oovf); else passed++;
    total++; if (bus.ofill !== 5'd16) $display("FAIL ovf_fill_hold got %0d want 16", bus.ofill); else passed++;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.ovalid) begin
        total++; if (bus.odata !== DW'(got + 1)) $display("FAIL ovf_drain got %0h want %0h", bus.odata, got + 1); else passed++;
        got++;
      end
      step();
      #1;
    end
    total++; if (got !== 18) $display("FAIL ovf_count got %0d want 18", got); else passed++;
    total++; if (bus.oempty !== 1'b1) $display("FAIL ovf_empty got %0h want 1", bus.oempty); else passed++;
    total++; if (bus.oovf !== 1'b1) $display("FAIL ovf_sticky got %0h want 1", bus.oovf); else passed++;
    step();
  endtask

  task automatic test_flush();
    bus.oready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus.ivalid = 1'b1;
      bus.idata  = DW'(8'h10 + c);
      step();
    end
    bus.iclr   = 1'b1;
    bus.idata  = 24'h000099;
    #1;
    total++; if (bus.ram_en_wr !== 1'b0) $display("FAIL flush_en_wr got %0h want 0", bus.ram_en_wr); else passed++;
    step();
    bus.iclr   = 1'b0;
    bus.ivalid = 1'b0;
    #1;
    total++; if (bus.ovalid !== 1'b0) $display("FAIL flush_ovalid got %0h want 0", bus.ovalid); else passed++;
    total++; if (bus.ofill !== 5'd0) $display("FAIL flush_ofill got %0d want 0", bus.ofill); else passed++;
    total++; if (bus.oempty !== 1'b1) $display("FAIL flush_oempty got %0h want 1", bus.oempty); else passed++;
    total++; if (bus.oovf !== 1'b0) $display("FAIL flush_oovf got %0h want 0", bus.oovf); else passed++;
    step();
    bus.oready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      bus.ivalid = (c == 0);
      bus.idata  = 24'h000055;
      #1;
      total++; if (bus.ovalid !== (c == 3)) $display("FAIL flush_ovalid c%0d got %0h want %0h", c, bus.ovalid, (c == 3)); else passed++;
      if (c == 3) begin
        total++; if (bus.odata !== 24'h000055) $display("FAIL flush_odata got %0h want 55", bus.odata); else passed++;
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int            got;
    logic          held_v;
    logic [DW-1:0] held;
    got    = 0;
    held_v = 1'b0;
    held   = '0;
    for (int c = 0; c < 60; c++) begin
      bus.ivalid = (c < 10);
      bus.idata  = DW'(c);
      bus.oready = ((c % 3) == 0);
      #1;
      if (held_v) begin
        total++; if (bus.ovalid !== 1'b1) $display("FAIL bp_hold_valid c%0d got %0h want 1", c, bus.ovalid); else passed++;
        total++; if (bus.odata !== held) $display("FAIL bp_hold_data c%0d got %0h want %0h", c, bus.odata, held); else passed++;
      end
      if (bus.ovalid && bus.oready) begin
        total++; if (bus.odata !== DW'(got)) $display("FAIL bp_order got %0h want %0h", bus.odata, got); else passed++;
        got++;
      end
      held_v = bus.ovalid && !bus.oready;
      held   = bus.odata;
      step();
    end
    total++; if (got !== 10) $display("FAIL bp_count got %0d want 10", got); else passed++;
    total++; if (bus.oovf !== 1'b0) $display("FAIL bp_oovf got %0h want 0", bus.oovf); else passed++;
  endtask

  task automatic test_wraparound();
    int wraps;
    bus.iclr   = 1'b1;
    bus.ivalid = 1'b0;
    step();
    bus.iclr   = 1'b0;
    bus.oready = 1'b1;
    wraps      = 0;
    for (int c = 0; c < 45; c++) begin
      bus.ivalid = (c < 40);
      bus.idata  = DW'(c);
      #1;
      if (c < 40) begin
        total++; if (bus.ram_en_wr !== 1'b1) $display("FAIL wrap_en_wr c%0d got %0h want 1", c, bus.ram_en_wr); else passed++;
        total++; if (bus.ram_wr_addr !== 4'(c % 16)) $display("FAIL wrap_addr c%0d got %0h want %0h", c, bus.ram_wr_addr, c % 16); else passed++;
        if (c > 0 && bus.ram_wr_addr == 4'd0) wraps++;
      end
      total++; if (bus.ovalid !== (c >= 3 && c <= 42)) $display("FAIL wrap_ovalid c%0d got %0h want %0h", c, bus.ovalid, (c >= 3 && c <= 42)); else passed++;
      if (c >= 3 && c <= 42) begin
        total++; if (bus.odata !== DW'(c - 3)) $display("FAIL wrap_odata c%0d got %0h want %0h", c, bus.odata, c - 3); else passed++;
      end
      step();
    end
    total++; if (wraps !== 2) $display("FAIL wrap_count got %0d want 2", wraps); else passed++;
    total++; if (bus.oovf !== 1'b0) $display("FAIL wrap_oovf got %0h want 0", bus.oovf); else passed++;
    total++; if (bus.oempty !== 1'b1) $display("FAIL wrap_oempty got %0h want 1", bus.oempty); else passed++;
  endtask

  task automatic test_async_reset();
    bus.oready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.ivalid = 1'b1;
      bus.idata  = DW'(8'h70 + c);
      step();
    end
    bus.ivalid = 1'b0;
    #1;
    total++; if (bus.ovalid !== 1'b1) $display("FAIL arst_pre_valid got %0h want 1", bus.ovalid); else passed++;
    total++; if (bus.ofill !== 5'd3) $display("FAIL arst_pre_fill got %0d want 3", bus.ofill); else passed++;
    #2;
    irst       = 1'b1;
    bus.ivalid = 1'b1;
    #1;
    total++; if (bus.ovalid !== 1'b0) $display("FAIL arst_ovalid got %0h want 0", bus.ovalid); else passed++;
    total++; if (bus.odata !== 24'h0) $display("FAIL arst_odata got %0h want 0", bus.odata); else passed++;
    total++; if (bus.ofill !== 5'd0) $display("FAIL arst_ofill got %0d want 0", bus.ofill); else passed++;
    total++; if (bus.ofull !== 1'b0) $display("FAIL arst_ofull got %0h want 0", bus.ofull); else passed++;
    total++; if (bus.oempty !== 1'b1) $display("FAIL arst_oempty got %0h want 1", bus.oempty); else passed++;
    total++; if (bus.oovf !== 1'b0) $display("FAIL arst_oovf got %0h want 0", bus.oovf); else passed++;
    total++; if (bus.ram_en_wr !== 1'b0) $display("FAIL arst_en_wr got %0h want 0", bus.ram_en_wr); else passed++;
    step();
    step();
    total++; if (bus.ram_en_wr !== 1'b0) $display("FAIL arst_en_wr_hold got %0h want 0", bus.ram_en_wr); else passed++;
    #2;
    irst       = 1'b0;
    bus.ivalid = 1'b0;
    step();
    test_latency(24'h123456);
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    irst       = 1'b0;
    bus.iclr   = 1'b0;
    bus.ivalid = 1'b0;
    bus.idata  = '0;
    bus.oready = 1'b0;
    #1;
    irst = 1'b1;
    test_reset();
    test_latency(24'h00ABCD);
    test_overflow();
    test_flush();
    test_backpressure();
    test_wraparound();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
